ahb_slave_port_arbiter: RTL

Parametrised per-slave AHB-lite arbiter, the successor of the current 2-master fixed-priority arbiter. It accepts NUM_M master request buses and forwards one of them to a single slave interface. It tracks separate address-phase and data-phase ownership, and keeps the grant locked for the whole of a defined-length or INCR burst. It supports fixed-priority mode (runtime-selectable top master) and round-robin mode. One instance sits in front of each slave interface block.

---
 rtl/ahb_slave_port_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave AHB-lite arbiter: forwards one of NUM_M masters to the slave,
// holds it through bursts and tracks the data-phase owner separately.

module ahb_spa_lane (
  input  logic hreset,
  input  logic hsel,
  input  logic trans_act,
  input  logic own_addr,
  input  logic own_data,
  input  logic hready_s,
  input  logic hresp_s,
  output logic req,
  output logic hready_m,
  output logic hresp_m
);
  assign req = hsel & trans_act;

  always_comb begin
    if (hreset)                   hready_m = 1'b1;
    else if (own_addr | own_data) hready_m = hready_s;
    else if (req)                 hready_m = 1'b0;
    else                          hready_m = 1'b1;
  end

  assign hresp_m = ~hreset & own_data & hresp_s;
endmodule

module ahb_slave_port_arbiter #(
  parameter  int NUM_M  = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int MODE   = 0,
  localparam int IW     = $clog2(NUM_M)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [IW-1:0]            PRIO_SEL,
  input  logic [NUM_M-1:0]         HSEL_M,
  input  logic [2*NUM_M-1:0]       HTRANS_M,
  input  logic [NUM_M*ADDR_W-1:0]  HADDR_M,
  input  logic [NUM_M-1:0]         HWRITE_M,
  input  logic [2*NUM_M-1:0]       HSIZE_M,
  input  logic [3*NUM_M-1:0]       HBURST_M,
  input  logic [NUM_M*DATA_W-1:0]  HWDATA_M,
  input  logic                     HREADY_S,
  input  logic                     HRESP_S,
  input  logic [DATA_W-1:0]        HRDATA_S,
  output logic                     HSEL_S,
  output logic [ADDR_W-1:0]        HADDR_S,
  output logic                     HWRITE_S,
  output logic [1:0]               HSIZE_S,
  output logic [1:0]               HTRANS_S,
  output logic [2:0]               HBURST_S,
  output logic [DATA_W-1:0]        HWDATA_S,
  output logic [NUM_M-1:0]         HREADY_M,
  output logic [NUM_M-1:0]         HRESP_M,
  output logic [DATA_W-1:0]        HRDATA_M,
  output logic [NUM_M-1:0]         GNT_ADDR,
  output logic [NUM_M-1:0]         GNT_DATA
);
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [1:0]        size;
    logic [1:0]        trans;
    logic [2:0]        burst;
  } ahb_ctl_t;

  ahb_ctl_t   [NUM_M-1:0]             m_ctl;
  logic       [NUM_M-1:0][DATA_W-1:0] m_wdata;
  logic       [NUM_M-1:0]             trans_act, req, req_arb, win;
  ahb_ctl_t                           own;
  logic       [IW-1:0]                own_idx;
  logic       [DATA_W-1:0]            wdata;

  logic [NUM_M-1:0] gnt_addr, gnt_data;
  logic [3:0]       cnt, cnt_n;
  logic             incr, incr_n, lock_n;
  logic [IW-1:0]    rr_ptr, rr_n;

  for (genvar i = 0; i < NUM_M; i++) begin : g_m
    assign m_ctl[i] = '{sel:   HSEL_M[i],
                        addr:  HADDR_M[i*ADDR_W +: ADDR_W],
                        write: HWRITE_M[i],
                        size:  HSIZE_M[2*i +: 2],
                        trans: HTRANS_M[2*i +: 2],
                        burst: HBURST_M[3*i +: 3]};
    assign m_wdata[i]   = HWDATA_M[i*DATA_W +: DATA_W];
    assign trans_act[i] = HTRANS_M[2*i+1];
  end

  ahb_spa_lane u_lane [NUM_M-1:0] (
    .hreset    (HRESET),
    .hsel      (HSEL_M),
    .trans_act (trans_act),
    .own_addr  (gnt_addr),
    .own_data  (gnt_data),
    .hready_s  (HREADY_S),
    .hresp_s   (HRESP_S),
    .req       (req),
    .hready_m  (HREADY_M),
    .hresp_m   (HRESP_M)
  );

  always_comb begin
    own     = '0;
    own_idx = '0;
    wdata   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_addr[i]) begin
        own     = m_ctl[i];
        own_idx = IW'(i);
      end
      if (gnt_data[i]) wdata = m_wdata[i];
    end
  end

  function automatic logic [3:0] beats_m1(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: beats_m1 = 4'd3;
      3'd4, 3'd5: beats_m1 = 4'd7;
      3'd6, 3'd7: beats_m1 = 4'd15;
      default:    beats_m1 = 4'd0;
    endcase
  endfunction

  // Lock is judged on the post-edge state so the edge taking a burst's
  // NONSEQ keeps the grant and the edge taking its last beat re-arbitrates.
  always_comb begin
    cnt_n  = cnt;
    incr_n = incr;
    rr_n   = rr_ptr;
    if (HRESP_S && !HREADY_S) begin
      cnt_n  = '0;
      incr_n = 1'b0;
    end else if (HREADY_S && (|gnt_addr)) begin
      case (own.trans)
        T_NONSEQ: begin
          cnt_n  = beats_m1(own.burst);
          incr_n = (own.burst == 3'd1);
          rr_n   = own_idx;
        end
        T_SEQ:   if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        T_IDLE:  incr_n = 1'b0;
        default: ;
      endcase
    end
    lock_n = (cnt_n != 4'd0) | incr_n;
  end

  // The owner's current transfer is being accepted at this edge, so it is
  // not a fresh request and must not win the bus back.
  assign req_arb = req & ~gnt_addr;

  always_comb begin
    int  s, idx;
    logic found;
    win   = '0;
    found = 1'b0;
    s     = (MODE == 1) ? (int'(rr_n) + 1) % NUM_M : int'(PRIO_SEL) % NUM_M;
    for (int j = 0; j < NUM_M; j++) begin
      idx = (s + j) % NUM_M;
      if (!found && req_arb[IW'(idx)]) begin
        win[IW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt_addr <= '0;
      gnt_data <= '0;
      cnt      <= '0;
      incr     <= 1'b0;
      rr_ptr   <= IW'(NUM_M - 1);
    end else begin
      cnt    <= cnt_n;
      incr   <= incr_n;
      rr_ptr <= rr_n;
      if (HREADY_S) begin
        gnt_data <= own.trans[1] ? gnt_addr : '0;
        if (!lock_n) gnt_addr <= win;
      end
    end
  end

  assign HSEL_S   = own.sel;
  assign HADDR_S  = own.addr;
  assign HWRITE_S = own.write;
  assign HSIZE_S  = own.size;
  assign HTRANS_S = own.trans;
  assign HBURST_S = own.burst;
  assign HWDATA_S = wdata;
  assign HRDATA_M = HRDATA_S;
  assign GNT_ADDR = gnt_addr;
  assign GNT_DATA = gnt_data;
endmodule
